// File: rtl/forwarding_unit_stg3.sv
// forwarding_unit_stg3: registered EX-stage operand forwarding selects; FWD_R0_GUARD_EN blocks forwarding of register 0
module forwarding_unit_stg3 #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] IDEXop1,
    input  logic [REG_ADDR_W-1:0] IDEXop2,
    input  logic [REG_ADDR_W-1:0] EXMEMop1,
    input  logic [REG_ADDR_W-1:0] EXMEMop2,
    input  logic [REG_ADDR_W-1:0] MEMWBop1,
    input  logic                  EXMEMregWrite,
    input  logic                  MEMWBregWrite,
    output logic [1:0]            F_Logic1,
    output logic [1:0]            F_Logic2,
    output logic                  fwd_any,
    output logic [CNT_W-1:0]      fwd_count
);
    logic       ok1, ok2, nxt_any;
    logic [1:0] nxt1, nxt2;
`ifdef FWD_R0_GUARD_EN
    assign ok1 = |IDEXop1;
    assign ok2 = |IDEXop2;
`else
    assign ok1 = 1'b1;
    assign ok2 = 1'b1;
`endif
    always_comb begin
        nxt1 = !ok1 ? 2'b00 :
               (EXMEMregWrite && IDEXop1 == EXMEMop1) ? 2'b01 :
               (EXMEMregWrite && IDEXop1 == EXMEMop2) ? 2'b10 :
               (MEMWBregWrite && IDEXop1 == MEMWBop1) ? 2'b11 : 2'b00;
        nxt2 = !ok2 ? 2'b00 :
               (EXMEMregWrite && IDEXop2 == EXMEMop1) ? 2'b01 :
               (EXMEMregWrite && IDEXop2 == EXMEMop2) ? 2'b10 :
               (MEMWBregWrite && IDEXop2 == MEMWBop1) ? 2'b11 : 2'b00;
        nxt_any = |{nxt1, nxt2};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            F_Logic1  <= 2'b00;
            F_Logic2  <= 2'b00;
            fwd_any   <= 1'b0;
            fwd_count <= '0;
        end else begin
            F_Logic1  <= nxt1;
            F_Logic2  <= nxt2;
            fwd_any   <= nxt_any;
            fwd_count <= (nxt_any && !(&fwd_count)) ? fwd_count + CNT_W'(1) : fwd_count;
        end
    end
endmodule

// File: tb/tb_forwarding_unit_stg3.sv
// tb_forwarding_unit_stg3: directed-vector bench for forwarding_unit_stg3
module tb_forwarding_unit_stg3;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] s1, s2, e1, e2, m1;
    logic       ew, mw;
    logic [1:0] f1, f2;
    logic       any;
    logic [7:0] cnt;
    int checks = 0;
    int failures = 0;

    forwarding_unit_stg3 #(.REG_ADDR_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .IDEXop1(s1), .IDEXop2(s2),
        .EXMEMop1(e1), .EXMEMop2(e2), .MEMWBop1(m1),
        .EXMEMregWrite(ew), .MEMWBregWrite(mw),
        .F_Logic1(f1), .F_Logic2(f2), .fwd_any(any), .fwd_count(cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] a1, a2, x1, x2, w1, input logic xw, ww);
        s1 = a1; s2 = a2; e1 = x1; e2 = x2; m1 = w1; ew = xw; mw = ww;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(5, 10, 5, 10, 5, 1, 1);
        drive(5, 10, 5, 10, 5, 1, 1);
        checks++; if (f1 !== 2'b00) begin failures++; $display("FAIL reset_f1 got=%b exp=00", f1); end
        checks++; if (f2 !== 2'b00) begin failures++; $display("FAIL reset_f2 got=%b exp=00", f2); end
        checks++; if (any !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", any); end
        checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        rst = 1'b0;
    endtask

    task automatic test_exmem;
        drive(5, 10, 5, 11, 14, 1, 0);
        checks++; if ({f1, f2, any} !== {2'b01, 2'b00, 1'b1}) begin failures++; $display("FAIL exmem_op1 got=%b_%b_%b exp=01_00_1", f1, f2, any); end
        checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL exmem_cnt got=%0d exp=1", cnt); end
        drive(5, 10, 11, 5, 14, 1, 0);
        checks++; if ({f1, f2} !== {2'b10, 2'b00}) begin failures++; $display("FAIL exmem_op2 got=%b_%b exp=10_00", f1, f2); end
        drive(5, 10, 10, 6, 14, 1, 0);
        checks++; if ({f1, f2} !== {2'b00, 2'b01}) begin failures++; $display("FAIL exmem_src2 got=%b_%b exp=00_01", f1, f2); end
    endtask

    task automatic test_memwb;
        drive(5, 10, 6, 11, 5, 0, 1);
        checks++; if ({f1, f2} !== {2'b11, 2'b00}) begin failures++; $display("FAIL memwb_src1 got=%b_%b exp=11_00", f1, f2); end
        drive(5, 10, 6, 11, 10, 0, 1);
        checks++; if ({f1, f2} !== {2'b00, 2'b11}) begin failures++; $display("FAIL memwb_src2 got=%b_%b exp=00_11", f1, f2); end
        drive(5, 10, 6, 11, 12, 1, 1);
        checks++; if ({f1, f2, any} !== {2'b00, 2'b00, 1'b0}) begin failures++; $display("FAIL no_match got=%b_%b_%b exp=00_00_0", f1, f2, any); end
        drive(5, 10, 5, 10, 5, 0, 0);
        checks++; if ({f1, f2, any} !== {2'b00, 2'b00, 1'b0}) begin failures++; $display("FAIL we_off got=%b_%b_%b exp=00_00_0", f1, f2, any); end
    endtask

    task automatic test_priority;
        drive(5, 10, 5, 10, 10, 1, 1);
        checks++; if ({f1, f2} !== {2'b01, 2'b10}) begin failures++; $display("FAIL prio_exmem got=%b_%b exp=01_10", f1, f2); end
        drive(5, 10, 5, 5, 10, 1, 1);
        checks++; if ({f1, f2} !== {2'b01, 2'b11}) begin failures++; $display("FAIL prio_op1 got=%b_%b exp=01_11", f1, f2); end
        drive(5, 10, 5, 5, 10, 0, 1);
        checks++; if ({f1, f2} !== {2'b00, 2'b11}) begin failures++; $display("FAIL prio_ex_off got=%b_%b exp=00_11", f1, f2); end
        drive(7, 7, 3, 7, 7, 1, 1);
        checks++; if ({f1, f2} !== {2'b10, 2'b10}) begin failures++; $display("FAIL prio_same got=%b_%b exp=10_10", f1, f2); end
    endtask

    task automatic test_reset_mid;
        drive(5, 10, 5, 11, 14, 1, 0);
        rst = 1'b1;
        drive(5, 10, 5, 11, 14, 1, 0);
        checks++; if ({f1, f2, any} !== {2'b00, 2'b00, 1'b0}) begin failures++; $display("FAIL mid_reset got=%b_%b_%b exp=00_00_0", f1, f2, any); end
        checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL mid_reset_cnt got=%0d exp=0", cnt); end
        rst = 1'b0;
        drive(5, 10, 5, 11, 14, 1, 0);
        checks++; if ({f1, any} !== {2'b01, 1'b1}) begin failures++; $display("FAIL resume got=%b_%b exp=01_1", f1, any); end
        checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL resume_cnt got=%0d exp=1", cnt); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 254; i++) drive(5, 10, 5, 11, 14, 1, 0);
        checks++; if (cnt !== 8'd255) begin failures++; $display("FAIL cnt_255 got=%0d exp=255", cnt); end
        for (int i = 0; i < 46; i++) drive(5, 10, 5, 11, 14, 1, 0);
        checks++; if (cnt !== 8'd255) begin failures++; $display("FAIL cnt_sat got=%0d exp=255", cnt); end
        drive(5, 10, 6, 11, 12, 1, 1);
        checks++; if (cnt !== 8'd255) begin failures++; $display("FAIL cnt_hold got=%0d exp=255", cnt); end
    endtask

    task automatic test_r0;
        logic [1:0] exp1;
`ifdef FWD_R0_GUARD_EN
        exp1 = 2'b00;
`else
        exp1 = 2'b01;
`endif
        drive(0, 10, 0, 11, 14, 1, 0);
        checks++; if (f1 !== exp1) begin failures++; $display("FAIL r0_f1 got=%b exp=%b", f1, exp1); end
        checks++; if (any !== |exp1) begin failures++; $display("FAIL r0_any got=%b exp=%b", any, |exp1); end
    endtask

    initial begin
        test_reset;
        test_exmem;
        test_memwb;
        test_priority;
        test_reset_mid;
        test_saturation;
        test_r0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/forwarding_unit_stg3.md
Name: forwarding_unit_stg3

Overview:
Operand-forwarding control for the EX stage (stage 3) of the pipelined datapath. Compares the two ID/EX source register addresses against the destinations in flight:
- EX/MEM carries two destinations, op1 and op2 (dual-write instructions).
- MEM/WB carries one destination, op1.

Produces a 2-bit mux select per ALU operand. Selects are registered: one cycle of latency, synchronous reset.

Parameters:
REG_ADDR_W, 4, width of every register address input.
CNT_W, 8, width of the saturating forward-event counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
IDEXop1  input  REG_ADDR_W  ID/EX source operand 1 register address
IDEXop2  input  REG_ADDR_W  ID/EX source operand 2 register address
EXMEMop1  input  REG_ADDR_W  EX/MEM destination 1 register address
EXMEMop2  input  REG_ADDR_W  EX/MEM destination 2 register address
MEMWBop1  input  REG_ADDR_W  MEM/WB destination register address
EXMEMregWrite  input  1  EX/MEM instruction writes the register file
MEMWBregWrite  input  1  MEM/WB instruction writes the register file
F_Logic1  output  2  forwarding select for ALU operand 1 (registered)
F_Logic2  output  2  forwarding select for ALU operand 2 (registered)
fwd_any  output  1  registered; 1 when either select is nonzero
fwd_count  output  CNT_W  saturating count of cycles with fwd_any asserted

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Select encoding:
  - 00 = no forward (register file value)
  - 01 = EX/MEM result 1 (EXMEMop1)
  - 10 = EX/MEM result 2 (EXMEMop2)
  - 11 = MEM/WB result (MEMWBop1)
- Next-state select for operand n (srcN = IDEXopN), evaluated in fixed priority order:
  1. EXMEMregWrite && srcN==EXMEMop1 -> 01
  2. else EXMEMregWrite && srcN==EXMEMop2 -> 10
  3. else MEMWBregWrite && srcN==MEMWBop1 -> 11
  4. else 00
- Priority:
  - EX/MEM (newer) beats MEM/WB.
  - Within EX/MEM, op1 beats op2 when both equal the source (EXMEMop1==EXMEMop2).
- Operands are evaluated independently. Both may forward in the same cycle, from the same or different sources.
- Write-enable low on a stage disables every match against that stage.
- Latency: the comparison is combinational on the inputs sampled at rising edge k. F_Logic1/F_Logic2/fwd_any reflect it after edge k; no combinational input-to-output path.
- fwd_any is registered in the same cycle as the selects: the OR of the next-state selects.
- fwd_count:
  - increments by 1 on each edge where the next-state fwd_any is 1.
  - saturates at 2^CNT_W-1 with no wrap.
- Reset: on a rising edge with rst=1, F_Logic1=00, F_Logic2=00, fwd_any=0, fwd_count=0. Reset overrides any simultaneous match.
- Reset mid-operation: outputs are 00 the cycle after rst is sampled high. Normal evaluation resumes on the first edge with rst=0.
- No X propagation requirements beyond the inputs: all outputs are always driven.

Optional Feature:
Macro FWD_R0_GUARD_EN.
- Defined: a source address of all-zeros (register 0, hardwired zero) never forwards. Its select is forced to 00 and it does not count toward fwd_any or fwd_count.
- Undefined: register 0 is treated like any other register and forwards on a match.

Test Plan:
- IDEXop1=5, IDEXop2=10, EXMEMop1=5, EXMEMop2=11, MEMWBop1=14, EXMEMregWrite=1, MEMWBregWrite=0 -> after next edge F_Logic1=01, F_Logic2=00, fwd_any=1.
- Same sources, EXMEMop1=11, EXMEMop2=5 -> F_Logic1=10, F_Logic2=00. With EXMEMop1=10, EXMEMop2=6 -> F_Logic1=00, F_Logic2=01.
- IDEXop1=5, IDEXop2=10, EXMEMop1=6, EXMEMop2=11, EXMEMregWrite=0, MEMWBregWrite=1:
  - MEMWBop1=5 -> F_Logic1=11, F_Logic2=00.
  - MEMWBop1=10 -> F_Logic1=00, F_Logic2=11.
- Both/priority:
  - EXMEMop1=5, EXMEMop2=10, MEMWBop1=10, EXMEMregWrite=1, MEMWBregWrite=1 -> F_Logic1=01, F_Logic2=10 (EX/MEM beats MEM/WB).
  - EXMEMop1=EXMEMop2=5 -> F_Logic1=01.
  - EXMEMregWrite=0 with the same addresses -> F_Logic2=11.
- Reset: drive a matching case, assert rst for one edge -> all selects 00, fwd_any=0, fwd_count=0. Deassert -> selects return one edge later. Hold a match for 300 cycles with CNT_W=8 -> fwd_count=255.
- IDEXop1=0, EXMEMop1=0, EXMEMregWrite=1 -> F_Logic1=00 with FWD_R0_GUARD_EN defined, 01 without.
